// File: rtl/shift_reg_piso.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready handshake
// and shifts it out LSB-first with framing strobes; back-to-back words have no gap.
module shift_reg_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             armed;
    logic             accept;

    // armed holds load_ready low until the first edge after reset releases.
    assign load_ready  = armed && ((state == IDLE) || (cnt == LAST));
    assign accept      = load_valid && load_ready;

    assign ser_valid   = (state == SHIFT);
    assign ser_out     = (state == SHIFT) && sh[0];
    assign frame_start = (state == SHIFT) && (cnt == '0);
    assign word_done   = (state == SHIFT) && (cnt == LAST);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh    <= par_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        sh  <= sh >> 1;
                        cnt <= cnt + CW'(1);
                    end else if (accept) begin
                        sh  <= par_in;
                        cnt <= '0;
                    end else begin
                        sh    <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_piso.sv
// Directed bench for shift_reg_piso (WIDTH=4): inputs change and outputs are
// sampled on the falling edge; a 4-stage SIPO model is chained on ser_out.
module tb_shift_reg_piso;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] par_in;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       word_done;
    logic [0:3] sipo;

    int errors = 0;
    int checks = 0;

    shift_reg_piso #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .par_in      (par_in),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .word_done   (word_done)
    );

    always #5 clk = ~clk;

    // Downstream SIPO declared [0:3]: new bits enter at index 0.
    always @(posedge clk) sipo <= {ser_out, sipo[0:2]};

    task automatic test_reset();
        reset = 1'b1;
        load_valid = 1'b0;
        par_in = 4'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ser_out, ser_valid, frame_start, word_done, load_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b want 00000", {ser_out, ser_valid, frame_start, word_done, load_ready});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", load_ready);
        end
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_edge: ready=%b valid=%b want 1 0", load_ready, ser_valid);
        end
    endtask

    task automatic test_single();
        logic [3:0] bits;
        bits = 4'b1011;
        load_valid = 1'b1;
        par_in = 4'b1011;
        @(negedge clk);
        load_valid = 1'b0;
        par_in = 4'h0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ser_out !== bits[k] || ser_valid !== 1'b1 || frame_start !== (k == 0) || word_done !== (k == 3)) begin
                errors++;
                $display("FAIL single_bit%0d: out=%b valid=%b fs=%b wd=%b want %b 1 %b %b",
                         k, ser_out, ser_valid, frame_start, word_done, bits[k], k == 0, k == 3);
            end
            @(negedge clk);
        end
        checks++;
        if (sipo !== 4'b1011 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_sipo: sipo=%b valid=%b want 1011 0", sipo, ser_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b0101_1010;  // bit c-1 is the serial bit of cycle c
        load_valid = 1'b1;
        par_in = 4'hA;
        @(negedge clk);
        par_in = 4'h5;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (ser_valid !== 1'b1 || ser_out !== bits[c-1] || load_ready !== (c == 4 || c == 8)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: valid=%b out=%b ready=%b want 1 %b %b",
                         c, ser_valid, ser_out, load_ready, bits[c-1], c == 4 || c == 8);
            end
            if (c == 5 && frame_start !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame_start: got %b want 1", frame_start);
            end
            if (c == 8) load_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (ser_valid !== 1'b0 || sipo !== 4'b0101) begin
            errors++;
            $display("FAIL b2b_end: valid=%b sipo=%b want 0 0101", ser_valid, sipo);
        end
    endtask

    task automatic test_handshake_ignore();
        logic [7:0] bits;
        logic [3:0] junk [3];
        bits = 8'b1100_0110;  // 4'h6 then 4'hC, LSB-first
        junk = '{4'hF, 4'h0, 4'h9};
        load_valid = 1'b1;
        par_in = 4'h6;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (ser_valid !== 1'b1 || ser_out !== bits[c-1]) begin
                errors++;
                $display("FAIL ignore_cycle%0d: valid=%b out=%b want 1 %b", c, ser_valid, ser_out, bits[c-1]);
            end
            if (c <= 3) begin
                load_valid = c[0];
                par_in = junk[c-1];
            end else if (c == 4) begin
                load_valid = 1'b1;
                par_in = 4'hC;
            end else begin
                load_valid = 1'b0;
                par_in = 4'h7;
            end
            @(negedge clk);
        end
        checks++;
        if (ser_valid !== 1'b0 || sipo !== 4'b1100) begin
            errors++;
            $display("FAIL ignore_end: valid=%b sipo=%b want 0 1100", ser_valid, sipo);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bits;
        bits = 4'b0011;
        load_valid = 1'b1;
        par_in = 4'hF;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);  // bit 1 on the line
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ser_out !== 1'b0 || ser_valid !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: out=%b valid=%b ready=%b want 0 0 0", ser_out, ser_valid, load_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b1 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: ready=%b valid=%b want 1 0", load_ready, ser_valid);
        end
        load_valid = 1'b1;
        par_in = 4'h3;
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ser_out !== bits[k] || ser_valid !== 1'b1 || frame_start !== (k == 0)) begin
                errors++;
                $display("FAIL after_reset_bit%0d: out=%b valid=%b fs=%b want %b 1 %b",
                         k, ser_out, ser_valid, frame_start, bits[k], k == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gap();
        logic [3:0] bits;
        bits = 4'b1000;
        load_valid = 1'b1;
        par_in = 4'h8;
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ser_out !== bits[k] || ser_valid !== 1'b1) begin
                errors++;
                $display("FAIL gap_first_bit%0d: out=%b valid=%b want %b 1", k, ser_out, ser_valid, bits[k]);
            end
            @(negedge clk);
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (ser_valid !== 1'b0 || ser_out !== 1'b0 || load_ready !== 1'b1) begin
                errors++;
                $display("FAIL gap_idle%0d: valid=%b out=%b ready=%b want 0 0 1", g, ser_valid, ser_out, load_ready);
            end
            if (g == 2) begin
                load_valid = 1'b1;
                par_in = 4'h1;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || ser_out !== 1'b1 || ser_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_second_start: fs=%b out=%b valid=%b want 1 1 1", frame_start, ser_out, ser_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (word_done !== 1'b1 || ser_out !== 1'b0) begin
            errors++;
            $display("FAIL gap_second_done: wd=%b out=%b want 1 0", word_done, ser_out);
        end
        @(negedge clk);
        checks++;
        if (sipo !== 4'b0001 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_sipo: sipo=%b valid=%b want 0001 0", sipo, ser_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_handshake_ignore();
        test_reset_mid();
        test_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
